// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU.
// Posts the HI/LO result for one cycle through whi/wlo once the op completes.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             whi,
  output logic             wlo,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_p;
  logic               neg_r;

  logic               accept;
  logic               sgn;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     m_sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     d_sh;
  logic               d_ge;
  logic [WIDTH-1:0]   d_sub;
  logic [2*WIDTH-1:0] div_nx;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign accept = (state == IDLE) && start && !flush;
  assign sgn    = ~op[0];
  assign a_abs  = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_abs  = (sgn && b[WIDTH-1]) ? -b : b;

  // one radix-2 step for each op kind
  always_comb begin
    m_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nx = {m_sum, acc[WIDTH-1:1]};
    d_sh   = acc[2*WIDTH-1:WIDTH-1];
    d_ge   = d_sh >= {1'b0, opb};
    d_sub  = d_sh[WIDTH-1:0] - opb;
    div_nx = {(d_ge ? d_sub : d_sh[WIDTH-1:0]), acc[WIDTH-2:0], d_ge};
  end

  // sign correction applied in FIX
  always_comb begin
    prod_fix = neg_p ? -acc : acc;
    q_fix    = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = CALC;
      end
      CALC: begin
        if (flush)                        state_nx = IDLE;
        else if (cnt == CW'(WIDTH - 1))   state_nx = FIX;
      end
      FIX: state_nx = flush ? IDLE : DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    whi = done;
    wlo = done;
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          cnt    <= '0;
          is_div <= op[1];
          neg_p  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1])
                    && (!op[1] || (b != '0));
          neg_r  <= sgn && op[1] && a[WIDTH-1];
          acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          opb    <= op[1] ? b_abs : a_abs;
        end
        (state == CALC): begin
          acc <= is_div ? div_nx : mul_nx;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
      if (state == FIX && !flush) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
// Directed corner cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         whi;
  logic         wlo;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .whi   (whi),
    .wlo   (wlo),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_res(
    input logic [1:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint p;
    int q;
    int r;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      2'b01: return {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b11) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int t0);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t0, input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic wait_done(input int t0, input int lat, input string tag);
    while (!done && (cyc - t0 < lat + 10)) @(negedge clk);
    chk({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
    chk({tag, "_pulse"}, {61'b0, done, whi, wlo}, 64'h7);
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input string tag);
    int t0;
    {exp_hi, exp_lo} = ref_res(o, x, y);
    launch(o, x, y, t0);
    chk({tag, "_busy"}, 64'(busy), 64'h1);
    wait_done(t0, 34, tag);
    @(negedge clk);
    chk({tag, "_end"}, {62'b0, busy, done}, 64'h0);
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done || whi || wlo) seen = 1'b1;
    end
    chk({tag, "_nowr"}, 64'(seen), 64'h0);
    chk({tag, "_hold"}, {hi_o, lo_o}, {exp_hi, exp_lo});
  endtask

  initial begin
    int t0;
    int t1;
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {60'b0, busy, done, whi, wlo}, 64'h0);
    chk("rst_res", {hi_o, lo_o}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t1_multu");
    do_op(2'b00, 32'hFFFF_FFFE, 32'h3, "t2_mult");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h2, "t2_div");
    do_op(2'b11, 32'h7, 32'h0, "t3_divu0");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "t3_divovf");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0, "div0_neg");

    launch(2'b11, 32'd100, 32'd7, t0);
    wait_cyc(t0, 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_busy", 64'(busy), 64'h0);
    quiet(40, "t4");

    {exp_hi, exp_lo} = ref_res(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
    launch(2'b00, 32'h1234_5678, 32'hFEDC_BA98, t0);
    wait_cyc(t0, 5);
    op    = 2'b11;
    a     = 32'd55;
    b     = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, 34, "t5_first");
    @(negedge clk);
    {exp_hi, exp_lo} = ref_res(2'b11, 32'd1000, 32'd33);
    launch(2'b11, 32'd1000, 32'd33, t1);
    wait_done(t1, 34, "t5_second");
    chk("t5_b2b", 64'(cyc - t0), 64'd69);
    @(negedge clk);

    launch(2'b01, 32'hDEAD_BEEF, 32'h1357_9BDF, t0);
    wait_cyc(t0, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_res", {hi_o, lo_o}, 64'h0);
    @(negedge clk);
    {exp_hi, exp_lo} = ref_res(2'b10, 32'hFFFF_FF00, 32'd9);
    launch(2'b10, 32'hFFFF_FF00, 32'd9, t1);
    wait_done(t1, 34, "t6_after");
    chk("t6_abs", 64'(cyc - t0), 64'd56);
    @(negedge clk);

    launch(2'b00, 32'h7, 32'h9, t0);
    wait_cyc(t0, 33);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fix_flush", {62'b0, busy, done}, 64'h0);
    quiet(5, "fix_flush");

    {exp_hi, exp_lo} = ref_res(2'b01, 32'hCAFE_F00D, 32'h0000_0100);
    launch(2'b01, 32'hCAFE_F00D, 32'h0000_0100, t0);
    wait_done(t0, 34, "done_flush");
    flush = 1'b1;
    #1;
    chk("done_flush_pulse", {62'b0, whi, wlo}, 64'h3);
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_res", {hi_o, lo_o}, {exp_hi, exp_lo});

    op    = 2'b01;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'h0);
    quiet(40, "idle_flush");

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: ry = 32'h1;
        2: ry = 32'hFFFF_FFFF;
        3: ry = $urandom_range(1, 20);
        4: rx = 32'h8000_0000;
        default: ;
      endcase
      do_op(ro, rx, ry, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
